mc_switch_alloc: RTL and testbench
==================================

Name: mc_switch_alloc

Overview:
- Switch allocator and output stage that consumes the per-input multicast routing results (three data/direction slots each for the W and N inputs) and forwards flit copies to five registered output ports.
- Drives rc_ready_W / rc_ready_N back to the routing stage once every requested copy of the current flit set has been delivered.
- Sits between routing computation and the link/crossbar outputs; it is the consumer end of the rc data/direction/ready interface.

Parameters:
- DATASIZE, 30, flit width in bits.

Ports:
- sa_clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- data_in_W1/W2/W3  in  DATASIZE each  W-input slot data
- direction_in_W1/W2/W3  in  5 each  W-input slot direction mask
- data_in_N1/N2/N3  in  DATASIZE each  N-input slot data
- direction_in_N1/N2/N3  in  5 each  N-input slot direction mask
- rc_ready_W  out  1  W flit set fully served; routing stage advances
- rc_ready_N  out  1  N flit set fully served
- out_data  out  5*DATASIZE  port p occupies bits [p*DATASIZE +: DATASIZE]
- out_valid  out  5  per-port valid
- out_ready  in  5  per-port downstream accept

Behaviour:
- Interface decision: one clock; the reset is asynchronous and active-high. Ports are named sa_clk and rst.
- Direction bit mapping: 0=Local, 1=N, 2=E, 3=S, 4=W. Each set bit is one copy request. An all-zero mask is an empty slot.
- Served mask:
  - Each of the 6 slots has a 5-bit served register.
  - pending = direction & ~served.
  - On grant: served |= grant bits.
- Port free condition: port p can accept a grant when (!out_valid[p] || out_ready[p]).
- Arbitration (per port p, every cycle, among slots with pending[p]=1):
  - One round-robin pointer bit per port selects the preferred input (0=W, 1=N).
  - The preferred input wins if any of its slots request p. Otherwise the other input wins.
  - Within the winning input, the lowest slot index wins (1 before 2 before 3).
  - After a grant, the pointer is set to the non-winning input. With no grant, the pointer holds.
  - A single slot may be granted several ports in the same cycle.
- Output register: on grant to port p, out_data[p] <= slot data and out_valid[p] <= 1 at the next edge. Latency is 1 cycle from request to out_valid.
- Output drain: if out_valid[p] && out_ready[p] with no new grant, out_valid[p] <= 0 and out_data[p] holds.
- Backpressure: out_valid[p] && !out_ready[p] holds the register. No grant to p; requests stay pending.
- Ready (combinational):
  - rc_ready_X = ((pending of X's 3 slots) & ~(this cycle's grants to X)) == 0.
  - An idle input therefore shows rc_ready=1.
  - At the edge where rc_ready_X=1, all three served masks of input X clear to 0, overriding that cycle's OR-in.
- Reset (async, rst=1):
  - out_valid=0, out_data=0, served=0, all pointers=0 (W).
  - Grants and rc_ready_W/N are forced to 0 while rst is high.
  - Reset mid-delivery discards partial progress; after release the current slots are re-served from scratch.
- Contention: when both inputs request the same port, the winner alternates each grant. A losing copy keeps its pending bit, and its input's rc_ready stays 0.
- Direction change: the served mask is valid only for the current flit. The routing stage must hold slot contents stable until rc_ready. The allocator does not check this.

Test Plan:
- Unicast: W1 = 0x1234567, dir 5'b00100, out_ready all 1, N idle -> cycle+1 out_valid=5'b00100, out_data[port2]=0x1234567. rc_ready_W=1 in the request cycle. served stays 0.
- Multicast in one slot: W1 dir 5'b10011 -> single cycle grants to ports 0, 1 and 4. Next cycle those three out_valid bits are set with identical data. rc_ready_W=1 in the request cycle.
- Contention: W1 dir 5'b00010 and N1 dir 5'b00010 with pointers reset -> W granted first, rc_ready_W=1, rc_ready_N=0. Next cycle N granted, rc_ready_N=1. port1 pointer ends at 0 (W).
- Backpressure: out_valid[3]=1 and out_ready[3]=0 for 4 cycles while W2 requests 5'b01000 -> no grant and rc_ready_W=0 for 4 cycles. Grant on the cycle out_ready[3] rises, and the new data appears the following cycle.
- Partial service: W1 dir 5'b00110, port2 blocked by a held out_valid -> port1 granted, served_W1=5'b00010, rc_ready_W=0. After the unblock, port2 is granted, rc_ready_W=1 and served clears to 0.
- Reset mid-operation: assert rst while served_W1=5'b00010 -> out_valid=0 immediately (async), rc_ready=0. After deassert, W1 dir 5'b00110 is re-served on both ports.

Source files
------------

// File: rtl/mc_switch_alloc.sv
// Switch allocator and registered output stage for the W/N multicast routing slots.
// Each slot keeps a served mask so a multicast flit is delivered once per requested port,
// and the routing stage is released only after every copy of the set has been granted.
module mc_switch_alloc #(
  parameter int DATASIZE = 30
) (
  input  logic                  sa_clk,
  input  logic                  rst,
  input  logic [DATASIZE-1:0]   data_in_W1,
  input  logic [DATASIZE-1:0]   data_in_W2,
  input  logic [DATASIZE-1:0]   data_in_W3,
  input  logic [4:0]            direction_in_W1,
  input  logic [4:0]            direction_in_W2,
  input  logic [4:0]            direction_in_W3,
  input  logic [DATASIZE-1:0]   data_in_N1,
  input  logic [DATASIZE-1:0]   data_in_N2,
  input  logic [DATASIZE-1:0]   data_in_N3,
  input  logic [4:0]            direction_in_N1,
  input  logic [4:0]            direction_in_N2,
  input  logic [4:0]            direction_in_N3,
  output logic                  rc_ready_W,
  output logic                  rc_ready_N,
  output logic [5*DATASIZE-1:0] out_data,
  output logic [4:0]            out_valid,
  input  logic [4:0]            out_ready
);

  // Slots 0..2 belong to the W input, 3..5 to the N input.
  logic [DATASIZE-1:0] slot_data [6];
  logic [4:0]          slot_dir  [6];
  logic [4:0]          served    [6];
  logic [4:0]          pending   [6];
  logic [4:0]          grant     [6];

  logic [4:0]          ptr;         // per port: 0 = prefer W, 1 = prefer N
  logic [4:0]          w_any;
  logic [4:0]          n_any;
  logic [4:0]          port_grant;
  logic [4:0]          win_n;       // per port: winner is N
  logic [4:0]          valid_q;
  logic [DATASIZE-1:0] out_reg   [5];
  logic [DATASIZE-1:0] grant_data[5];

  assign slot_data[0] = data_in_W1;
  assign slot_data[1] = data_in_W2;
  assign slot_data[2] = data_in_W3;
  assign slot_data[3] = data_in_N1;
  assign slot_data[4] = data_in_N2;
  assign slot_data[5] = data_in_N3;
  assign slot_dir[0]  = direction_in_W1;
  assign slot_dir[1]  = direction_in_W2;
  assign slot_dir[2]  = direction_in_W3;
  assign slot_dir[3]  = direction_in_N1;
  assign slot_dir[4]  = direction_in_N2;
  assign slot_dir[5]  = direction_in_N3;

  // Outstanding copy requests per slot.
  always_comb begin
    for (int unsigned s = 0; s < 6; s++) begin
      pending[s] = slot_dir[s] & ~served[s];
    end
  end

  // Per-port arbitration, vectorised across the five ports: preferred input first,
  // lowest slot index within the winning input.
  always_comb begin
    w_any      = pending[0] | pending[1] | pending[2];
    n_any      = pending[3] | pending[4] | pending[5];
    port_grant = rst ? '0 : ((w_any | n_any) & (~valid_q | out_ready));
    win_n      = (ptr & n_any) | (~ptr & ~w_any);
    grant[0]   = port_grant & ~win_n & pending[0];
    grant[1]   = port_grant & ~win_n & pending[1] & ~pending[0];
    grant[2]   = port_grant & ~win_n & pending[2] & ~pending[1] & ~pending[0];
    grant[3]   = port_grant &  win_n & pending[3];
    grant[4]   = port_grant &  win_n & pending[4] & ~pending[3];
    grant[5]   = port_grant &  win_n & pending[5] & ~pending[4] & ~pending[3];
  end

  // Data of the single slot granted to each port.
  always_comb begin
    for (int unsigned p = 0; p < 5; p++) begin
      grant_data[p] = '0;
      for (int unsigned s = 0; s < 6; s++) begin
        if (grant[s][p]) grant_data[p] = slot_data[s];
      end
    end
  end

  // Flit set is complete when nothing stays pending after this cycle's grants.
  always_comb begin
    rc_ready_W = !rst && (((pending[0] & ~grant[0]) | (pending[1] & ~grant[1]) |
                           (pending[2] & ~grant[2])) == 5'b0);
    rc_ready_N = !rst && (((pending[3] & ~grant[3]) | (pending[4] & ~grant[4]) |
                           (pending[5] & ~grant[5])) == 5'b0);
  end

  // Served masks: accumulate grants, cleared when the input's set is released.
  always_ff @(posedge sa_clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < 6; s++) served[s] <= '0;
    end else begin
      for (int unsigned s = 0; s < 3; s++) begin
        served[s] <= rc_ready_W ? 5'b0 : (served[s] | grant[s]);
      end
      for (int unsigned s = 3; s < 6; s++) begin
        served[s] <= rc_ready_N ? 5'b0 : (served[s] | grant[s]);
      end
    end
  end

  // Round-robin pointers: after a grant, prefer the input that lost.
  always_ff @(posedge sa_clk or posedge rst) begin
    if (rst) ptr <= '0;
    else     ptr <= (ptr & ~port_grant) | (port_grant & ~win_n);
  end

  // Output registers: load on grant, drain on accept, hold under backpressure.
  always_ff @(posedge sa_clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int unsigned p = 0; p < 5; p++) out_reg[p] <= '0;
    end else begin
      valid_q <= port_grant | (valid_q & ~out_ready);
      for (int unsigned p = 0; p < 5; p++) begin
        if (port_grant[p]) out_reg[p] <= grant_data[p];
      end
    end
  end

  // Pack the per-port registers onto the flat output bus.
  always_comb begin
    out_data = '0;
    for (int unsigned p = 0; p < 5; p++) begin
      out_data[p*DATASIZE +: DATASIZE] = out_reg[p];
    end
  end

  assign out_valid = valid_q;

endmodule

// File: tb/tb_mc_switch_alloc.sv
// Directed bench for mc_switch_alloc: stimulus pushes expected per-port flits into
// queues, a negedge monitor pops and compares on every out_valid/out_ready handshake.
module tb_mc_switch_alloc;

  localparam int DW = 30;

  logic              clk;
  logic              rst;
  logic [DW-1:0]     wd [3];
  logic [4:0]        wr [3];
  logic [DW-1:0]     nd [3];
  logic [4:0]        nr [3];
  logic              rc_ready_W;
  logic              rc_ready_N;
  logic [5*DW-1:0]   out_data;
  logic [4:0]        out_valid;
  logic [4:0]        out_ready;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] expq [5][$];
  logic [DW-1:0] mon_exp;

  mc_switch_alloc #(.DATASIZE(DW)) dut (
    .sa_clk(clk), .rst(rst),
    .data_in_W1(wd[0]), .data_in_W2(wd[1]), .data_in_W3(wd[2]),
    .direction_in_W1(wr[0]), .direction_in_W2(wr[1]), .direction_in_W3(wr[2]),
    .data_in_N1(nd[0]), .data_in_N2(nd[1]), .data_in_N3(nd[2]),
    .direction_in_N1(nr[0]), .direction_in_N2(nr[1]), .direction_in_N3(nr[2]),
    .rc_ready_W(rc_ready_W), .rc_ready_N(rc_ready_N),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pdata(input int p);
    return out_data[p*DW +: DW];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic idle_slots();
    for (int i = 0; i < 3; i++) begin
      wd[i] = '0; wr[i] = '0; nd[i] = '0; nr[i] = '0;
    end
  endtask

  // Scoreboard monitor: every accepted output must match the oldest expected flit of its port.
  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < 5; p++) begin
        if (out_valid[p] && out_ready[p]) begin
          if (expq[p].size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL port%0d unexpected: got %0h expected none", p, pdata(p));
          end else begin
            mon_exp = expq[p].pop_front();
            chk($sformatf("port%0d data", p), 32'(pdata(p)), 32'(mon_exp));
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    out_ready = 5'h1f;
    idle_slots();

    // Reset state; requests are ignored while reset is held.
    #3;
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset out_data", 32'(|out_data), 32'h0);
    chk("reset rc_ready_W", 32'(rc_ready_W), 32'h0);
    chk("reset rc_ready_N", 32'(rc_ready_N), 32'h0);
    wd[0] = 30'h155; wr[0] = 5'b00001;
    #1 chk("reset rc_ready_W with req", 32'(rc_ready_W), 32'h0);
    tick();
    chk("no grant in reset", 32'(out_valid), 32'h0);
    idle_slots();
    tick();
    rst = 1'b0;

    // Contention on port 1: W wins first, then N; pointer returns to W.
    wd[0] = 30'h0A0A0A0; wr[0] = 5'b00010; nd[0] = 30'h0B0B0B0; nr[0] = 5'b00010;
    expq[1].push_back(30'h0A0A0A0); expq[1].push_back(30'h0B0B0B0);
    neg();
    chk("cont1 rc_ready_W", 32'(rc_ready_W), 32'h1);
    chk("cont1 rc_ready_N", 32'(rc_ready_N), 32'h0);
    tick();
    wr[0] = '0;
    chk("cont1 out_valid", 32'(out_valid), 32'h02);
    chk("cont1 port1", 32'(pdata(1)), 32'h0A0A0A0);
    neg();
    chk("cont2 rc_ready_N", 32'(rc_ready_N), 32'h1);
    chk("cont2 rc_ready_W idle", 32'(rc_ready_W), 32'h1);
    tick();
    nr[0] = '0;
    chk("cont2 port1", 32'(pdata(1)), 32'h0B0B0B0);
    wd[0] = 30'h0C0C0C0; wr[0] = 5'b00010; nd[0] = 30'h0D0D0D0; nr[0] = 5'b00010;
    expq[1].push_back(30'h0C0C0C0); expq[1].push_back(30'h0D0D0D0);
    neg();
    chk("cont3 ptr back to W", 32'(rc_ready_W), 32'h1);
    chk("cont3 rc_ready_N", 32'(rc_ready_N), 32'h0);
    tick();
    wr[0] = '0;
    chk("cont3 port1", 32'(pdata(1)), 32'h0C0C0C0);
    neg();
    tick();
    nr[0] = '0;
    chk("cont4 port1", 32'(pdata(1)), 32'h0D0D0D0);
    tick();
    chk("cont drained", 32'(out_valid), 32'h0);

    // Unicast W1 -> E.
    wd[0] = 30'h1234567; wr[0] = 5'b00100;
    expq[2].push_back(30'h1234567);
    neg();
    chk("uni rc_ready_W", 32'(rc_ready_W), 32'h1);
    chk("uni rc_ready_N idle", 32'(rc_ready_N), 32'h1);
    tick();
    wr[0] = '0;
    chk("uni out_valid", 32'(out_valid), 32'h04);
    chk("uni port2", 32'(pdata(2)), 32'h1234567);
    tick();
    chk("uni drained", 32'(out_valid), 32'h0);

    // Multicast W1 -> Local, N, W in one cycle.
    wd[0] = 30'h0ABCDEF; wr[0] = 5'b10011;
    for (int p = 0; p < 5; p++) if (p != 2 && p != 3) expq[p].push_back(30'h0ABCDEF);
    neg();
    chk("mc rc_ready_W", 32'(rc_ready_W), 32'h1);
    tick();
    wr[0] = '0;
    chk("mc out_valid", 32'(out_valid), 32'h13);
    chk("mc port0", 32'(pdata(0)), 32'h0ABCDEF);
    chk("mc port4", 32'(pdata(4)), 32'h0ABCDEF);
    tick();
    chk("mc drained", 32'(out_valid), 32'h0);

    // Backpressure on port 3 for 4 cycles while W2 requests it.
    wd[0] = 30'h0E0E0E0; wr[0] = 5'b01000;
    expq[3].push_back(30'h0E0E0E0);
    tick();
    wr[0] = '0;
    out_ready = 5'b10111;
    wd[1] = 30'h0F0F0F0; wr[1] = 5'b01000;
    expq[3].push_back(30'h0F0F0F0);
    chk("bp loaded", 32'(out_valid[3]), 32'h1);
    for (int i = 0; i < 4; i++) begin
      neg();
      chk($sformatf("bp%0d rc_ready_W", i), 32'(rc_ready_W), 32'h0);
      tick();
      chk($sformatf("bp%0d port3 held", i), 32'(pdata(3)), 32'h0E0E0E0);
    end
    out_ready = 5'h1f;
    neg();
    chk("bp release rc_ready_W", 32'(rc_ready_W), 32'h1);
    tick();
    wr[1] = '0;
    chk("bp new valid", 32'(out_valid[3]), 32'h1);
    chk("bp new port3", 32'(pdata(3)), 32'h0F0F0F0);
    tick();

    // Partial service: port 2 blocked, port 1 served once only.
    nd[0] = 30'h0606060; nr[0] = 5'b00100;
    expq[2].push_back(30'h0606060);
    tick();
    nr[0] = '0;
    out_ready = 5'b11011;
    wd[0] = 30'h0707070; wr[0] = 5'b00110;
    expq[1].push_back(30'h0707070); expq[2].push_back(30'h0707070);
    neg();
    chk("part rc_ready_W", 32'(rc_ready_W), 32'h0);
    tick();
    chk("part out_valid", 32'(out_valid), 32'h06);
    chk("part port1", 32'(pdata(1)), 32'h0707070);
    neg();
    chk("part rc_ready_W held", 32'(rc_ready_W), 32'h0);
    tick();
    chk("part no regrant", 32'(out_valid), 32'h04);
    out_ready = 5'h1f;
    neg();
    chk("part unblock rc_ready_W", 32'(rc_ready_W), 32'h1);
    tick();
    wr[0] = '0;
    chk("part out_valid2", 32'(out_valid), 32'h04);
    chk("part port2", 32'(pdata(2)), 32'h0707070);
    wd[0] = 30'h0808080; wr[0] = 5'b00110;
    expq[1].push_back(30'h0808080); expq[2].push_back(30'h0808080);
    neg();
    chk("served cleared rc_ready_W", 32'(rc_ready_W), 32'h1);
    tick();
    wr[0] = '0;
    chk("served cleared out_valid", 32'(out_valid), 32'h06);
    tick();

    // Reset in the middle of a partially served multicast.
    nd[0] = 30'h0909090; nr[0] = 5'b00100;
    expq[2].push_back(30'h0909090);
    tick();
    nr[0] = '0;
    out_ready = 5'b11011;
    wd[0] = 30'h0313131; wr[0] = 5'b00110;
    expq[1].push_back(30'h0313131);
    neg();
    chk("rst pre rc_ready_W", 32'(rc_ready_W), 32'h0);
    tick();
    chk("rst pre port1", 32'(pdata(1)), 32'h0313131);
    neg();
    chk("rst pre partial", 32'(rc_ready_W), 32'h0);
    #2;
    rst = 1'b1;
    for (int p = 0; p < 5; p++) expq[p].delete();
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'h0);
    chk("async rst out_data", 32'(|out_data), 32'h0);
    chk("async rst rc_ready_W", 32'(rc_ready_W), 32'h0);
    chk("async rst rc_ready_N", 32'(rc_ready_N), 32'h0);
    tick();
    chk("rst held out_valid", 32'(out_valid), 32'h0);
    out_ready = 5'h1f;
    rst = 1'b0;
    expq[1].push_back(30'h0313131); expq[2].push_back(30'h0313131);
    neg();
    chk("post rst rc_ready_W", 32'(rc_ready_W), 32'h1);
    tick();
    wr[0] = '0;
    chk("post rst out_valid", 32'(out_valid), 32'h06);
    chk("post rst port1", 32'(pdata(1)), 32'h0313131);
    chk("post rst port2", 32'(pdata(2)), 32'h0313131);
    tick();
    tick();

    for (int p = 0; p < 5; p++) begin
      chk($sformatf("port%0d leftovers", p), 32'(expq[p].size()), 32'h0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
